keypad_debouncer: RTL and testbench

Parametrised multi-channel debouncer for the microwave front-panel keys. It sits between the raw active-low key pins and the key encoder. Each channel has its own synchroniser, stability counter and debounced state, and produces a clean level plus one-cycle press and release pulses. A registered key code reports the lowest-indexed key accepted in each cycle.

---
 rtl/keypad_debouncer_if.sv | 18 +
 rtl/keypad_debouncer.sv | 130 +++++++++++++
 tb/tb_keypad_debouncer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_debouncer_if.sv
// Key-panel bundle between the raw key pins and the key encoder.
// slave = debouncer side, master = panel/encoder side.
interface keypad_debouncer_if #(
  parameter int CHANNELS = 12,
  parameter int CODE_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0] key_n;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] press_pulse;
  logic [CHANNELS-1:0] release_pulse;
  logic                key_valid;
  logic [CODE_W-1:0]   key_code;

  modport master (output key_n,
                  input  pressed, press_pulse, release_pulse, key_valid, key_code);
  modport slave  (input  key_n,
                  output pressed, press_pulse, release_pulse, key_valid, key_code);
endinterface

// File: rtl/keypad_debouncer.sv
// Multi-channel active-low key debouncer with press/release pulses and lowest-key encoder.
// Optional auto-repeat of press_pulse when KEYPAD_DEBOUNCE_AUTOREPEAT_EN is defined.
module kpd_chan #(
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed,
  output logic press_nxt,
  output logic rel_nxt
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          s, mismatch, hit;

  assign s        = ~sync2;
  assign mismatch = s ^ pressed;
  assign hit      = mismatch && (cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (!mismatch || hit) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      if (hit) pressed <= ~pressed;
    end
  end

  assign rel_nxt = hit & pressed;

`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rcnt;
  logic          rphase;  // 0: waiting out the initial delay, 1: in periodic repeat
  logic          rep;

  assign rep = pressed && !hit &&
               (rcnt == (rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (hit || !pressed) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (rep) begin
      rcnt   <= '0;
      rphase <= 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  assign press_nxt = (hit & ~pressed) | rep;
`else
  assign press_nxt = hit & ~pressed;
`endif
endmodule

module keypad_debouncer #(
  parameter int CHANNELS      = 12,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 8
) (
  input logic               clk,
  input logic               rst_n,
  keypad_debouncer_if.slave kp
);
  localparam int CODE_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pressed_q, press_nxt, rel_nxt;
  logic [CHANNELS-1:0] press_q, rel_q;
  logic                valid_q;
  logic [CODE_W-1:0]   code_q, code_nxt;

  kpd_chan #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_chan [CHANNELS-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_n     (kp.key_n),
    .pressed   (pressed_q),
    .press_nxt (press_nxt),
    .rel_nxt   (rel_nxt)
  );

  // Scan downward so the lowest set index wins.
  always_comb begin
    code_nxt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (press_nxt[i]) code_nxt = CODE_W'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_q <= '0;
      rel_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      press_q <= press_nxt;
      rel_q   <= rel_nxt;
      valid_q <= |press_nxt;
      if (|press_nxt) code_q <= code_nxt;
    end
  end

  assign kp.pressed       = pressed_q;
  assign kp.press_pulse   = press_q;
  assign kp.release_pulse = rel_q;
  assign kp.key_valid     = valid_q;
  assign kp.key_code      = code_q;
endmodule

// File: tb/tb_keypad_debouncer.sv
// Randomised + directed bench for keypad_debouncer against a timestamp-based reference model.
module tb_keypad_debouncer;
  localparam int CH = 12, SC = 4, RD = 16, RP = 8;
  localparam int CW = $clog2(CH);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_debouncer_if #(.CHANNELS(CH)) kp ();

  keypad_debouncer #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a 2-deep delay line for the synchroniser, then acceptance
  // when the last SC samples all disagree with the level and postdate the last change.
  int            cyc = 0;
  logic [CH-1:0] m_d1, m_d2, m_pr, m_pp, m_rp;
  logic          m_v;
  logic [CW-1:0] m_code;
  int            run_start [CH];
  int            acc_at    [CH];

  task automatic model_step();
    logic [CH-1:0] s;
    cyc++;
    if (!rst_n) begin
      m_d1 = '1; m_d2 = '1; m_pr = '0; m_pp = '0; m_rp = '0; m_v = 1'b0; m_code = '0;
      for (int i = 0; i < CH; i++) begin run_start[i] = -1; acc_at[i] = 0; end
    end else begin
      s = ~m_d2;
      m_d2 = m_d1;
      m_d1 = kp.key_n;
      m_pp = '0; m_rp = '0;
      for (int i = 0; i < CH; i++) begin
        if (s[i] == m_pr[i]) run_start[i] = -1;
        else begin
          if (run_start[i] < 0) run_start[i] = cyc;
          if (cyc - run_start[i] + 1 >= SC) begin
            if (m_pr[i]) m_rp[i] = 1'b1;
            else begin m_pp[i] = 1'b1; acc_at[i] = cyc; end
            m_pr[i] = ~m_pr[i];
            run_start[i] = -1;
          end
        end
`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
        if (m_pr[i] && !m_pp[i] && !m_rp[i]) begin
          int d;
          d = cyc - acc_at[i];
          if (d >= RD && (d - RD) % RP == 0) m_pp[i] = 1'b1;
        end
`endif
      end
      m_v = |m_pp;
      if (m_v)
        for (int i = CH - 1; i >= 0; i--) if (m_pp[i]) m_code = CW'(i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("pressed",       32'(kp.pressed),       32'(m_pr));
    chk("press_pulse",   32'(kp.press_pulse),   32'(m_pp));
    chk("release_pulse", 32'(kp.release_pulse), 32'(m_rp));
    chk("key_valid",     32'(kp.key_valid),     32'(m_v));
    chk("key_code",      32'(kp.key_code),      32'(m_code));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Returns the edge count (1 = first edge after the input change) of the pulse, or -1.
  task automatic wait_pulse(input bit rel, input int ch, output int n);
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (rel ? kp.release_pulse[ch] : kp.press_pulse[ch]) begin n = k; break; end
    end
  endtask

  int n, bounce_pulses;
  int hold_left [CH];
  int rep_off[$];

  initial begin
    kp.key_n = '0;
    rst_n = 1'b0;
    ticks(3);
    chk("rst_pressed", 32'(kp.pressed), 0);
    chk("rst_press",   32'(kp.press_pulse), 0);
    chk("rst_valid",   32'(kp.key_valid), 0);
    chk("rst_code",    32'(kp.key_code), 0);

    rst_n = 1'b1;
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (kp.press_pulse == '1) begin n = k; break; end
    end
    chk("rst_reaccept_lat", n - 1, SC + 1);
    ticks(3);
    kp.key_n = '1;
    ticks(10);

    kp.key_n[3] = 1'b0;
    wait_pulse(1'b0, 3, n);
    chk("press3_lat",   n - 1, SC + 1);
    chk("press3_code",  32'(kp.key_code), 3);
    chk("press3_valid", 32'(kp.key_valid), 1);
    tick();
    chk("press3_once",  32'(kp.press_pulse[3]), 0);
    ticks(8);

    kp.key_n[3] = 1'b1;
    wait_pulse(1'b1, 3, n);
    chk("rel3_lat",     n - 1, SC + 1);
    chk("rel3_pressed", 32'(kp.pressed[3]), 0);
    chk("rel3_valid",   32'(kp.key_valid), 0);
    ticks(5);

    bounce_pulses = 0;
    for (int t = 0; t < 40; t++) begin
      kp.key_n[0] = (t % 3 == 0);
      tick();
      if (kp.press_pulse[0] || kp.release_pulse[0]) bounce_pulses++;
    end
    chk("bounce_nopulse", bounce_pulses, 0);
    kp.key_n[0] = 1'b0;
    wait_pulse(1'b0, 0, n);
    chk("bounce_lat", n - 1, SC + 1);
    ticks(3);
    kp.key_n[0] = 1'b1;
    ticks(10);

    kp.key_n[7] = 1'b0;
    kp.key_n[2] = 1'b0;
    wait_pulse(1'b0, 2, n);
    chk("simul_lat",  n - 1, SC + 1);
    chk("simul_pp",   32'(kp.press_pulse), 32'h084);
    chk("simul_code", 32'(kp.key_code), 2);
    ticks(3);
    kp.key_n = '1;
    ticks(10);

`ifdef KEYPAD_DEBOUNCE_AUTOREPEAT_EN
    kp.key_n[5] = 1'b0;
    wait_pulse(1'b0, 5, n);
    chk("rep_first_lat", n - 1, SC + 1);
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (kp.press_pulse[5]) rep_off.push_back(k);
      if (k == 50) kp.key_n[5] = 1'b1;
    end
    chk("rep_count", rep_off.size(), 5);
    for (int j = 0; j < rep_off.size() && j < 5; j++)
      chk("rep_offset", rep_off[j], 16 + 8 * j);
    ticks(5);
`endif

    for (int i = 0; i < CH; i++) hold_left[i] = $urandom_range(1, 12);
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < CH; i++) begin
        if (hold_left[i] == 0) begin
          kp.key_n[i] = ~kp.key_n[i];
          hold_left[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(SC + 1, 40)
                                                     : $urandom_range(1, 2 * SC);
        end else hold_left[i]--;
      end
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 0) rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;
    ticks(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
